hitor_tdc: RTL and testbench

- Sits directly downstream of the chip's LVDS HITOR output, inside the FPGA core, and upstream of the readout arbiter that feeds the BRAM FIFO.
- Measures each HITOR pulse: rising-edge timestamp and width in clock cycles.
- Packs each pulse into one 32-bit tagged data word and buffers it in a small FIFO.
- Presents the words on the standard FIFO_READ/FIFO_EMPTY/FIFO_DATA arbiter interface.

---
 rtl/hitor_tdc_pkg.sv | 30 +++
 rtl/hitor_tdc_fifo.sv | 60 ++++++
 rtl/hitor_tdc.sv | 117 +++++++++++
 tb/tb_hitor_tdc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hitor_tdc_pkg.sv
// Shared types and word-field layout for the HITOR time-to-digital converter.
package hitor_tdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    PUSH    = 2'd2
  } state_t;

  localparam int ID_MSB    = 31;
  localparam int ID_LSB    = 28;
  localparam int WIDTH_MSB = 27;
  localparam int WIDTH_LSB = 16;
  localparam int TS_MSB    = 15;
  localparam int TS_LSB    = 0;

  localparam logic [11:0] WIDTH_MAX = 12'hFFF;

  function automatic logic [31:0] pack_word(input logic [3:0] id,
                                            input logic [11:0] width,
                                            input logic [15:0] ts);
    logic [31:0] w;
    w = '0;
    w[ID_MSB:ID_LSB]       = id;
    w[WIDTH_MSB:WIDTH_LSB] = width;
    w[TS_MSB:TS_LSB]       = ts;
    return w;
  endfunction

endpackage

// File: rtl/hitor_tdc_fifo.sv
// First-word-fall-through FIFO with a registered head word; pushes while full are refused.
module hitor_tdc_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [AW:0]   count_reg;
  logic [DW-1:0] dout_reg;
  logic          push_ok, pop_ok;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign dout       = dout_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_inc;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      // Head register refills from the next stored word, or straight from din
      // when the incoming word becomes the new head.
      if (pop_ok) begin
        if (count_reg > (AW+1)'(1)) dout_reg <= mem[rd_ptr_inc];
        else if (push_ok)           dout_reg <= din;
      end else if (empty && push_ok) begin
        dout_reg <= din;
      end
    end
  end

endmodule

// File: rtl/hitor_tdc.sv
// HITOR pulse timestamp/width measurement feeding a tagged-word FWFT FIFO.
module hitor_tdc
  import hitor_tdc_pkg::*;
#(
  parameter logic [3:0] IDENTIFIER = 4'b0100,
  parameter int         DEPTH      = 16,
  parameter int         WIDTH_BITS = 12
) (
  input  logic        CLK,
  input  logic        RESETB,
  input  logic        EN,
  input  logic        HITOR,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic [15:0] HIT_CNT,
  output logic [7:0]  LOST_CNT,
  output logic        BUSY
);

  state_t                state_reg, state_next;
  logic                  sync_reg, hs_reg, hs_d_reg;
  logic                  rise, fall;
  logic [15:0]           ts_cnt_reg, ts_reg;
  logic [WIDTH_BITS-1:0] width_reg;
  logic [15:0]           hit_cnt_reg;
  logic [7:0]            lost_cnt_reg;
  logic                  start, inc_width, do_push, fifo_full;

  assign rise = hs_reg & ~hs_d_reg;
  assign fall = ~hs_reg & hs_d_reg;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      sync_reg   <= 1'b0;
      hs_reg     <= 1'b0;
      hs_d_reg   <= 1'b0;
      ts_cnt_reg <= '0;
      state_reg  <= IDLE;
    end else begin
      sync_reg   <= HITOR;
      hs_reg     <= sync_reg;
      hs_d_reg   <= hs_reg;
      ts_cnt_reg <= ts_cnt_reg + 16'd1;
      state_reg  <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    inc_width  = 1'b0;
    do_push    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise && EN) begin
          start      = 1'b1;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (!EN)       state_next = IDLE;
        else if (hs_reg) inc_width = 1'b1;
        else if (fall) state_next = PUSH;
      end
      PUSH: begin
        do_push = 1'b1;
        // A new rise landing on the push cycle is accepted back-to-back.
        if (rise && EN) begin
          start      = 1'b1;
          state_next = MEASURE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      ts_reg       <= '0;
      width_reg    <= '0;
      hit_cnt_reg  <= '0;
      lost_cnt_reg <= '0;
    end else begin
      if (start) begin
        ts_reg      <= ts_cnt_reg;
        width_reg   <= WIDTH_BITS'(1);
        hit_cnt_reg <= hit_cnt_reg + 16'd1;
      end else if (inc_width && width_reg != WIDTH_MAX) begin
        width_reg <= width_reg + WIDTH_BITS'(1);
      end
      if (do_push && fifo_full && lost_cnt_reg != 8'hFF)
        lost_cnt_reg <= lost_cnt_reg + 8'd1;
    end
  end

  hitor_tdc_fifo #(
    .DEPTH (DEPTH),
    .DW    (32)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETB),
    .push  (do_push),
    .din   (pack_word(IDENTIFIER, width_reg, ts_reg)),
    .pop   (FIFO_READ),
    .full  (fifo_full),
    .empty (FIFO_EMPTY),
    .dout  (FIFO_DATA)
  );

  assign HIT_CNT  = hit_cnt_reg;
  assign LOST_CNT = lost_cnt_reg;
  assign BUSY     = (state_reg != IDLE);

endmodule

// File: tb/tb_hitor_tdc.sv
// Directed self-checking bench for hitor_tdc with hand-computed word values.
module tb_hitor_tdc;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESETB = 1'b0;
  logic        EN = 1'b0;
  logic        HITOR = 1'b0;
  logic        FIFO_READ = 1'b0;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic [15:0] HIT_CNT;
  logic [7:0]  LOST_CNT;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  logic [15:0] cyc;
  logic [15:0] ts_a, ts_b;
  logic [15:0] ts_q [DEPTH+3];

  hitor_tdc #(.IDENTIFIER(4'b0100), .DEPTH(DEPTH), .WIDTH_BITS(12)) dut (
    .CLK(CLK), .RESETB(RESETB), .EN(EN), .HITOR(HITOR),
    .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .HIT_CNT(HIT_CNT), .LOST_CNT(LOST_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference cycle counter: equals the timestamp value held during each cycle.
  always @(posedge CLK or negedge RESETB) begin
    if (!RESETB) cyc <= 16'd0;
    else         cyc <= cyc + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  function automatic logic [31:0] word(input logic [11:0] w, input logic [15:0] ts);
    return {4'b0100, w, ts};
  endfunction

  task automatic wait_ts(input logic [15:0] target);
    int n = 0;
    while (cyc != target && n < 70000) begin
      @(negedge CLK);
      n++;
    end
    if (cyc != target) check("wait_ts", {16'h0, cyc}, {16'h0, target});
  endtask

  // Raise HITOR for 'high' cycles; ts is the timestamp of the synchronized rise.
  task automatic send(input int high, output logic [15:0] ts);
    ts = cyc + 16'd2;
    HITOR = 1'b1;
    repeat (high) @(negedge CLK);
    HITOR = 1'b0;
  endtask

  task automatic pop();
    FIFO_READ = 1'b1;
    @(negedge CLK);
    FIFO_READ = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_empty", {31'h0, FIFO_EMPTY}, 32'd1);
    check("rst_data", FIFO_DATA, 32'h0);
    check("rst_hits", {16'h0, HIT_CNT}, 32'd0);
    check("rst_lost", {24'h0, LOST_CNT}, 32'd0);
    check("rst_busy", {31'h0, BUSY}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESETB = 1'b1;
    EN = 1'b1;

    // Basic 10-cycle pulse at TS=0x0100, latency check
    wait_ts(16'h00FE);
    send(10, ts_a);
    exp_hits++;
    repeat (3) @(negedge CLK);
    check("t1_empty_push", {31'h0, FIFO_EMPTY}, 32'd1);
    check("t1_busy_push", {31'h0, BUSY}, 32'd1);
    @(negedge CLK);
    check("t1_empty", {31'h0, FIFO_EMPTY}, 32'd0);
    check("t1_word", FIFO_DATA, 32'h400A_0100);
    check("t1_hits", {16'h0, HIT_CNT}, exp_hits);
    pop();
    check("t1_drained", {31'h0, FIFO_EMPTY}, 32'd1);
    check("t1_data_hold", FIFO_DATA, 32'h400A_0100);

    // Long pulse saturates width
    repeat (3) @(negedge CLK);
    ts_a = cyc + 16'd2;
    HITOR = 1'b1;
    repeat (5000) @(negedge CLK);
    check("t2_no_early_word", {31'h0, FIFO_EMPTY}, 32'd1);
    check("t2_busy", {31'h0, BUSY}, 32'd1);
    HITOR = 1'b0;
    exp_hits++;
    repeat (4) @(negedge CLK);
    check("t2_word", FIFO_DATA, word(12'hFFF, ts_a));
    pop();
    check("t2_one_word", {31'h0, FIFO_EMPTY}, 32'd1);

    // Back-to-back: second rise on the PUSH cycle
    repeat (3) @(negedge CLK);
    send(3, ts_a);
    @(negedge CLK);
    send(4, ts_b);
    exp_hits += 2;
    repeat (5) @(negedge CLK);
    check("t3_word0", FIFO_DATA, word(12'd3, ts_a));
    pop();
    check("t3_word1", FIFO_DATA, word(12'd4, ts_a + 16'd4));
    pop();
    check("t3_empty", {31'h0, FIFO_EMPTY}, 32'd1);
    check("t3_hits", {16'h0, HIT_CNT}, exp_hits);

    // Overflow: DEPTH+3 pulses without reading
    for (int i = 0; i < DEPTH + 3; i++) begin
      send(2, ts_q[i]);
      repeat (3) @(negedge CLK);
    end
    exp_hits += DEPTH + 3;
    repeat (4) @(negedge CLK);
    check("t4_lost", {24'h0, LOST_CNT}, 32'd3);
    check("t4_hits", {16'h0, HIT_CNT}, exp_hits);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t4_drain%0d", i), FIFO_DATA, word(12'd2, ts_q[i]));
      pop();
    end
    check("t4_empty", {31'h0, FIFO_EMPTY}, 32'd1);

    // EN dropped mid-pulse aborts; EN raised while high does not start
    HITOR = 1'b1;
    repeat (5) @(negedge CLK);
    check("t5_busy_meas", {31'h0, BUSY}, 32'd1);
    EN = 1'b0;
    exp_hits++;
    @(negedge CLK);
    check("t5_busy_abort", {31'h0, BUSY}, 32'd0);
    HITOR = 1'b0;
    repeat (5) @(negedge CLK);
    HITOR = 1'b1;
    repeat (4) @(negedge CLK);
    EN = 1'b1;
    repeat (5) @(negedge CLK);
    check("t5_busy_nostart", {31'h0, BUSY}, 32'd0);
    HITOR = 1'b0;
    repeat (6) @(negedge CLK);
    check("t5_no_word", {31'h0, FIFO_EMPTY}, 32'd1);
    check("t5_hits", {16'h0, HIT_CNT}, exp_hits);
    send(6, ts_a);
    exp_hits++;
    repeat (4) @(negedge CLK);
    check("t5_clean", FIFO_DATA, word(12'd6, ts_a));
    pop();

    // Timestamp wrap
    wait_ts(16'hFFFC);
    send(2, ts_a);
    wait_ts(16'h0001);
    send(2, ts_b);
    repeat (5) @(negedge CLK);
    check("t6_ts_fffe", FIFO_DATA, word(12'd2, 16'hFFFE));
    pop();
    check("t6_ts_0003", FIFO_DATA, word(12'd2, 16'h0003));

    // Asynchronous reset during MEASURE
    HITOR = 1'b1;
    repeat (4) @(negedge CLK);
    check("t6_busy", {31'h0, BUSY}, 32'd1);
    RESETB = 1'b0;
    #1;
    check("ar_empty", {31'h0, FIFO_EMPTY}, 32'd1);
    check("ar_data", FIFO_DATA, 32'h0);
    check("ar_hits", {16'h0, HIT_CNT}, 32'd0);
    check("ar_lost", {24'h0, LOST_CNT}, 32'd0);
    check("ar_busy", {31'h0, BUSY}, 32'd0);
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
